// File: rtl/envelope_shift_sequencer.sv
// Per-voice volume envelope: sequences a 4-bit attenuation shift through
// decay -> sustain -> release and pulses env_done when the voice falls silent.
module envelope_shift_sequencer #(
  parameter int unsigned RATE_W       = 16,
  parameter int unsigned SILENT_SHIFT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              note_on,
  input  logic              note_off,
  input  logic [3:0]        sustain_shift,
  input  logic [RATE_W-1:0] decay_rate,
  input  logic [RATE_W-1:0] release_rate,
  output logic [3:0]        shift_amount,
  output logic              busy,
  output logic              env_done,
  output logic [1:0]        phase
);

  localparam logic [3:0] SILENT = 4'(SILENT_SHIFT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        shift_q, shift_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [3:0]        sus_q, sus_d;
  logic [RATE_W-1:0] drate_q, drate_d;
  logic [RATE_W-1:0] rrate_q, rrate_d;
  logic              done_q, done_d;
  logic              busy_q;

  logic              step_dec;
  logic              step_rel;
  logic [3:0]        shift_inc;

  assign step_dec  = (cnt_q == drate_q);
  assign step_rel  = (cnt_q == rrate_q);
  assign shift_inc = shift_q + 4'd1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sus_d   = sus_q;
    drate_d = drate_q;
    rrate_d = rrate_q;
    done_d  = 1'b0;

    if (note_on) begin
      // Restart from any state; a coincident note_off or pending step is dropped.
      state_d = DECAY;
      shift_d = '0;
      cnt_d   = '0;
      sus_d   = sustain_shift;
      drate_d = decay_rate;
    end else if (note_off && (state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
      cnt_d   = '0;
      rrate_d = release_rate;
    end else begin
      case (state_q)
        IDLE: begin
          shift_d = SILENT;
          cnt_d   = '0;
        end
        DECAY: begin
          if (shift_q == sus_q) begin
            state_d = SUSTAIN;
            cnt_d   = '0;
          end else if (step_dec) begin
            cnt_d = '0;
            if (shift_q != 4'hF) shift_d = shift_inc;
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        SUSTAIN: begin
          cnt_d = '0;
        end
        RELEASE: begin
          if (shift_q >= SILENT) begin
            state_d = IDLE;
            shift_d = SILENT;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else if (step_rel) begin
            cnt_d   = '0;
            shift_d = shift_inc;
            if (shift_inc == SILENT) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + RATE_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          shift_d = SILENT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= SILENT;
      cnt_q   <= '0;
      sus_q   <= '0;
      drate_q <= '0;
      rrate_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sus_q   <= sus_d;
      drate_q <= drate_d;
      rrate_q <= rrate_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign shift_amount = shift_q;
  assign busy         = busy_q;
  assign env_done     = done_q;
  assign phase        = state_q;

endmodule
